clk_ratio_meter: RTL and testbench

Measures an asynchronous clock, typically a fractional-divider output, in units of `clk_fast` cycles. It counts the `clk_fast` cycles spanned by a programmed number of `clk_in` rising edges, so that software or a control loop can recover the achieved divide ratio. It sits at the receiving end of a divider output: self-test, closed-loop ratio trimming, or measuring an external reference.

---
 rtl/clk_ratio_meter_if.sv | 23 ++
 rtl/clk_ratio_meter.sv | 145 ++++++++++++++
 tb/tb_clk_ratio_meter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_ratio_meter_if.sv
// Control/result bundle for clk_ratio_meter: start request and target in, status and result out.
interface clk_ratio_meter_if #(
  parameter int CLEN = 24,
  parameter int ELEN = 16
);
  logic            start;
  logic [ELEN-1:0] n_edges;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [CLEN-1:0] cyc_cnt;
  logic            edge_seen;

  modport master (
    output start, n_edges,
    input  busy, done, ovf, cyc_cnt, edge_seen
  );

  modport slave (
    input  start, n_edges,
    output busy, done, ovf, cyc_cnt, edge_seen
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// Counts clk_fast cycles spanned by n_edges periods of an asynchronous clk_in.
// Optional macro CLK_RATIO_METER_GLITCH_FILTER_EN requires two low then two high samples per edge.
module clk_ratio_meter #(
  parameter int CLEN = 24,
  parameter int ELEN = 16
) (
  input  logic                clk_fast,
  input  logic                rst_n,
  input  logic                clk_in,
  clk_ratio_meter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;

  localparam logic [CLEN-1:0] KMAX = '1;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
`ifdef CLK_RATIO_METER_GLITCH_FILTER_EN
  logic s4_q, s4_d;
`endif
  logic e;

  state_e          state_q, state_d;
  logic [CLEN-1:0] k_q, k_d;
  logic [CLEN-1:0] cyc_q, cyc_d;
  logic [ELEN-1:0] ec_q, ec_d;
  logic [ELEN-1:0] tgt_q, tgt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            es_q, es_d;

  // Synchronizer chain and edge detector
  always_comb begin
    s1_d = clk_in;
    s2_d = s1_q;
    s3_d = s2_q;
`ifdef CLK_RATIO_METER_GLITCH_FILTER_EN
    s4_d = s3_q;
    e    = ~s4_q & ~s3_q & s2_q & s1_q;
`else
    e    = s2_q & ~s3_q;
`endif
    es_d = e;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cyc_d   = cyc_q;
    ec_d    = ec_q;
    tgt_d   = tgt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.n_edges != '0)) begin
          tgt_d   = bus.n_edges;
          cyc_d   = '0;
          ovf_d   = 1'b0;
          k_d     = '0;
          ec_d    = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (e) begin
          k_d     = CLEN'(1);
          ec_d    = '0;
          state_d = MEAS;
        end else if (k_q == KMAX) begin
          ovf_d   = 1'b1;
          cyc_d   = KMAX;
          state_d = DONE;
        end else begin
          k_d = k_q + CLEN'(1);
        end
      end
      MEAS: begin
        // Completion takes priority over saturation on the same cycle
        if (e && ((ec_q + ELEN'(1)) == tgt_q)) begin
          cyc_d   = k_q;
          state_d = DONE;
        end else begin
          if (e) ec_d = ec_q + ELEN'(1);
          if (k_q == KMAX) begin
            ovf_d   = 1'b1;
            cyc_d   = KMAX;
            state_d = DONE;
          end else begin
            k_d = k_q + CLEN'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
`ifdef CLK_RATIO_METER_GLITCH_FILTER_EN
      s4_q    <= 1'b0;
`endif
      es_q    <= 1'b0;
      state_q <= IDLE;
      k_q     <= '0;
      cyc_q   <= '0;
      ec_q    <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
`ifdef CLK_RATIO_METER_GLITCH_FILTER_EN
      s4_q    <= s4_d;
`endif
      es_q    <= es_d;
      state_q <= state_d;
      k_q     <= k_d;
      cyc_q   <= cyc_d;
      ec_q    <= ec_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.cyc_cnt   = cyc_q;
  assign bus.edge_seen = es_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: a 24-bit instance for ratio tests, an 8-bit one for timeout.
module tb_clk_ratio_meter;

  typedef struct {
    logic [31:0] cyc;
    logic        ovf;
    int          tol;
  } exp_t;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b0;
  logic gen_clk  = 1'b0;
  logic glitch   = 1'b0;
  logic clk_in;
  logic clk_in8  = 1'b0;

  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   done8_cnt = 0;
  int   es_cnt = 0;
  int   g_hi = 5;
  int   g_lo = 5;
  bit   gen_en = 1'b0;

  exp_t exp_q[$];
  exp_t exp8_q[$];

  always #5 clk_fast = ~clk_fast;
  assign clk_in = gen_clk | glitch;

  clk_ratio_meter_if #(.CLEN(24), .ELEN(16)) bus ();
  clk_ratio_meter_if #(.CLEN(8),  .ELEN(16)) bus8 ();

  clk_ratio_meter #(.CLEN(24), .ELEN(16)) u_dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .clk_in   (clk_in),
    .bus      (bus.slave)
  );

  clk_ratio_meter #(.CLEN(8), .ELEN(16)) u_dut8 (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .clk_in   (clk_in8),
    .bus      (bus8.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int tol = 0);
    int diff;
    n_vec++;
    diff = (got > exp) ? int'(got - exp) : int'(exp - got);
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Synchronous clk_in generator, phases measured in clk_fast cycles
  initial begin
    forever begin
      if (gen_en) begin
        gen_clk = 1'b1;
        repeat (g_hi) @(negedge clk_fast);
        gen_clk = 1'b0;
        repeat (g_lo) @(negedge clk_fast);
      end else begin
        @(negedge clk_fast);
      end
    end
  end

  always @(negedge clk_fast) begin : mon
    exp_t x;
    if (rst_n && bus.edge_seen) es_cnt <= es_cnt + 1;
    if (rst_n && bus.done) begin
      done_cnt <= done_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        x = exp_q.pop_front();
        check("cyc_cnt", 32'(bus.cyc_cnt), x.cyc, x.tol);
        check("ovf", 32'(bus.ovf), 32'(x.ovf));
      end
    end
    if (rst_n && bus8.done) begin
      done8_cnt <= done8_cnt + 1;
      if (exp8_q.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        x = exp8_q.pop_front();
        check("cyc_cnt8", 32'(bus8.cyc_cnt), x.cyc, x.tol);
        check("ovf8", 32'(bus8.ovf), 32'(x.ovf));
      end
    end
  end

  task automatic do_start(input int n, input bit sel = 1'b0);
    if (sel) begin
      bus8.start   = 1'b1;
      bus8.n_edges = 16'(n);
    end else begin
      bus.start    = 1'b1;
      bus.n_edges  = 16'(n);
    end
    @(negedge clk_fast);
    bus.start  = 1'b0;
    bus8.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output int took, output int busy_lo);
    took    = 0;
    busy_lo = 0;
    while (took < budget) begin
      @(negedge clk_fast);
      took++;
      if (!(sel ? bus8.busy : bus.busy)) busy_lo++;
      if ((sel ? bus8.done : bus.done) === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_period(input int hi, input int lo);
    gen_en = 1'b0;
    repeat (14) @(negedge clk_fast);
    g_hi   = hi;
    g_lo   = lo;
    gen_en = 1'b1;
    repeat (3) @(negedge clk_fast);
  endtask

  initial begin
    int took, blo, d0, e0, bl;
    bus.start = 1'b0;  bus.n_edges = '0;
    bus8.start = 1'b0; bus8.n_edges = '0;
    repeat (3) @(negedge clk_fast);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_cyc", 32'(bus.cyc_cnt), 32'd0);
    check("rst_edge_seen", 32'(bus.edge_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_fast);

    // Period 10, four periods
    set_period(5, 5);
    exp_q.push_back(exp_t'{32'd40, 1'b0, 1});
    do_start(4);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(1'b0, 300, took, blo);
    check("busy_held", 32'(blo), 32'd0);
    @(negedge clk_fast);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("done_single", 32'(bus.done), 32'd0);

    // Start in the cycle right after done is accepted
    exp_q.push_back(exp_t'{32'd20, 1'b0, 1});
    do_start(2);
    check("turnaround_busy", 32'(bus.busy), 32'd1);
    wait_done(1'b0, 300, took, blo);
    @(negedge clk_fast);

    // n_edges = 0 is ignored
    d0 = done_cnt;
    bl = 0;
    do_start(0);
    repeat (100) begin
      if (bus.busy) bl++;
      @(negedge clk_fast);
    end
    check("n0_busy", 32'(bl), 32'd0);
    check("n0_done", 32'(done_cnt - d0), 32'd0);

    // Period 7, single period
    set_period(4, 3);
    exp_q.push_back(exp_t'{32'd7, 1'b0, 1});
    do_start(1);
    wait_done(1'b0, 300, took, blo);
    @(negedge clk_fast);

    // Restart attempt mid-measurement is ignored
    set_period(5, 5);
    exp_q.push_back(exp_t'{32'd30, 1'b0, 1});
    do_start(3);
    repeat (25) @(negedge clk_fast);
    do_start(1);
    wait_done(1'b0, 300, took, blo);
    @(negedge clk_fast);

    // Reset during measurement
    d0 = done_cnt;
    do_start(4);
    repeat (20) @(negedge clk_fast);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    check("midrst_cyc", 32'(bus.cyc_cnt), 32'd0);
    repeat (3) @(negedge clk_fast);
    rst_n = 1'b1;
    repeat (60) @(negedge clk_fast);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back(exp_t'{32'd20, 1'b0, 1});
    do_start(2);
    wait_done(1'b0, 300, took, blo);
    @(negedge clk_fast);

    // 8-bit counter, clk_in stuck low: timeout
    exp8_q.push_back(exp_t'{32'd255, 1'b1, 0});
    do_start(2, 1'b1);
    wait_done(1'b1, 400, took, blo);
    check("timeout_latency", 32'(took), 32'd256, 2);
    @(negedge clk_fast);
    do_start(1, 1'b1);
    check("ovf_cleared", 32'(bus8.ovf), 32'd0);
    check("cyc_cleared", 32'(bus8.cyc_cnt), 32'd0);
    exp8_q.push_back(exp_t'{32'd255, 1'b1, 0});
    wait_done(1'b1, 400, took, blo);
    @(negedge clk_fast);

    // Single-cycle glitch on a quiet clk_in
    gen_en = 1'b0;
    repeat (15) @(negedge clk_fast);
    e0 = es_cnt;
    glitch = 1'b1;
    @(negedge clk_fast);
    glitch = 1'b0;
    repeat (10) @(negedge clk_fast);
`ifdef CLK_RATIO_METER_GLITCH_FILTER_EN
    check("glitch_edges", 32'(es_cnt - e0), 32'd0);
`else
    check("glitch_edges", 32'(es_cnt - e0), 32'd1);
`endif

    check("pending_results", 32'(exp_q.size() + exp8_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
